// File: rtl/adam_periph_spi_seq.sv
// SPI transaction sequencer: applies a frame config under PHY pause, then gates
// exactly cmd_len words through the PHY tx/rx streams before re-pausing.
module adam_periph_spi_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_tx_enable,
    input  logic                  cmd_rx_enable,
    input  logic                  cmd_mode_select,
    input  logic                  cmd_clock_phase,
    input  logic                  cmd_clock_polarity,
    input  logic                  cmd_data_order,
    input  logic [7:0]            cmd_data_length,
    input  logic [DATA_WIDTH-1:0] cmd_baud_rate,
    input  logic [LEN_WIDTH-1:0]  cmd_len,

    input  logic [DATA_WIDTH-1:0] s_tx,
    input  logic                  s_tx_valid,
    output logic                  s_tx_ready,
    output logic [DATA_WIDTH-1:0] m_rx,
    output logic                  m_rx_valid,
    input  logic                  m_rx_ready,

    output logic                  busy,
    output logic                  done,

    output logic                  phy_pause_req,
    input  logic                  phy_pause_ack,
    output logic                  phy_tx_enable,
    output logic                  phy_rx_enable,
    output logic                  phy_mode_select,
    output logic                  phy_clock_phase,
    output logic                  phy_clock_polarity,
    output logic                  phy_data_order,
    output logic [7:0]            phy_data_length,
    output logic [DATA_WIDTH-1:0] phy_baud_rate,

    output logic [DATA_WIDTH-1:0] phy_tx,
    output logic                  phy_tx_valid,
    input  logic                  phy_tx_ready,
    input  logic [DATA_WIDTH-1:0] phy_rx,
    input  logic                  phy_rx_valid,
    output logic                  phy_rx_ready
);

    typedef enum logic [1:0] {StIdle, StApply, StRun, StDrain} state_e;

    state_e                 state_q, state_d;
    logic                   pause_req_q;
    logic                   done_q, done_d;
    logic                   load;
    logic [LEN_WIDTH-1:0]   len_q, tx_cnt_q, rx_cnt_q;
    logic                   tx_en_q, rx_en_q, mode_q, pha_q, pol_q, order_q;
    logic [7:0]             dlen_q;
    logic [DATA_WIDTH-1:0]  baud_q;
    logic                   tx_go, rx_go, tx_hs, rx_hs, tx_done, rx_done;

    // Streams only open in RUN, and each direction closes itself once len words moved.
    assign tx_go   = (state_q == StRun) && tx_en_q && (tx_cnt_q < len_q);
    assign rx_go   = (state_q == StRun) && rx_en_q && (rx_cnt_q < len_q);
    assign tx_hs   = phy_tx_valid && phy_tx_ready;
    assign rx_hs   = phy_rx_valid && phy_rx_ready;
    assign tx_done = !tx_en_q || (tx_cnt_q == len_q);
    assign rx_done = !rx_en_q || (rx_cnt_q == len_q);

    assign phy_tx       = s_tx;
    assign phy_tx_valid = s_tx_valid && tx_go;
    assign s_tx_ready   = phy_tx_ready && tx_go;
    assign m_rx         = phy_rx;
    assign m_rx_valid   = phy_rx_valid && rx_go;
    assign phy_rx_ready = m_rx_ready && rx_go;

    assign cmd_ready     = !rst && (state_q == StIdle) && phy_pause_ack;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign phy_pause_req = pause_req_q;

    assign phy_tx_enable      = tx_en_q;
    assign phy_rx_enable      = rx_en_q;
    assign phy_mode_select    = mode_q;
    assign phy_clock_phase    = pha_q;
    assign phy_clock_polarity = pol_q;
    assign phy_data_order     = order_q;
    assign phy_data_length    = dlen_q;
    assign phy_baud_rate      = baud_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    // Empty transfers complete immediately without touching the PHY config.
                    if ((cmd_len == '0) || !(cmd_tx_enable || cmd_rx_enable)) begin
                        done_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = StApply;
                    end
                end
            end
            StApply: state_d = StRun;
            StRun: begin
                if (tx_done && rx_done) state_d = StDrain;
            end
            StDrain: begin
                if (phy_pause_ack) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pause_req_q <= 1'b1;
            done_q      <= 1'b0;
            len_q       <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tx_en_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            mode_q      <= 1'b1;
            pha_q       <= 1'b0;
            pol_q       <= 1'b0;
            order_q     <= 1'b0;
            dlen_q      <= '0;
            baud_q      <= '0;
        end else begin
            state_q     <= state_d;
            pause_req_q <= (state_d != StRun);
            done_q      <= done_d;
            if (load) begin
                len_q    <= cmd_len;
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
                tx_en_q  <= cmd_tx_enable;
                rx_en_q  <= cmd_rx_enable;
                mode_q   <= cmd_mode_select;
                pha_q    <= cmd_clock_phase;
                pol_q    <= cmd_clock_polarity;
                order_q  <= cmd_data_order;
                dlen_q   <= cmd_data_length;
                baud_q   <= cmd_baud_rate;
            end else begin
                if (tx_hs) tx_cnt_q <= tx_cnt_q + LEN_WIDTH'(1);
                if (rx_hs) rx_cnt_q <= rx_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/adam_periph_spi_seq.md
Name: adam_periph_spi_seq

Overview:
Transaction sequencer that sits between the SPI peripheral register front-end and the SPI PHY.
It accepts one command at a time, carrying a frame configuration and a word count.
It uses the PHY pause handshake to apply the configuration safely, then gates exactly N words through the PHY tx/rx streams.
It re-pauses the PHY on completion and pulses done.
The PHY is held paused whenever the sequencer is idle.

Parameters:
DATA_WIDTH, 32, width of tx/rx words and of baud_rate.
LEN_WIDTH, 16, width of the word-count field.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
cmd_tx_enable, cmd_rx_enable, cmd_mode_select, cmd_clock_phase, cmd_clock_polarity, cmd_data_order  in  1 each  frame config for this command
cmd_data_length  in  8  bits per word
cmd_baud_rate  in  DATA_WIDTH  PHY baud divider
cmd_len  in  LEN_WIDTH  words in the transaction
s_tx, s_tx_valid, s_tx_ready  in/in/out  DATA_WIDTH/1/1  tx word stream from front-end
m_rx, m_rx_valid, m_rx_ready  out/out/in  DATA_WIDTH/1/1  rx word stream to front-end
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of transaction
phy_pause_req  out  1  to PHY pause_req
phy_pause_ack  in  1  from PHY pause_ack
phy_tx_enable … phy_baud_rate  out  as cmd_*  registered config to PHY
phy_tx, phy_tx_valid, phy_tx_ready  out/out/in  DATA_WIDTH/1/1  PHY tx stream
phy_rx, phy_rx_valid, phy_rx_ready  in/in/out  DATA_WIDTH/1/1  PHY rx stream

Behaviour:
- Reset values:
  - state = IDLE, phy_pause_req = 1.
  - All phy_* config outputs = 0, except phy_mode_select = 1.
  - tx_cnt = rx_cnt = 0; busy = 0, done = 0, cmd_ready = 0.
  - Reset mid-transaction aborts the transaction and does not pulse done.
- States: IDLE, APPLY, RUN, DRAIN.
- IDLE:
  - phy_pause_req = 1.
  - cmd_ready = phy_pause_ack (combinational).
  - On cmd_valid && cmd_ready:
    - latch all cmd_* fields into the phy_* config registers and latch len.
    - clear the counters.
    - go to APPLY.
  - Exception: if cmd_len == 0 or both enables are 0, stay in IDLE, leave the config registers unchanged, and pulse done on the next cycle.
- APPLY:
  - Exactly 1 cycle, phy_pause_req still 1 (config settles while req && ack).
  - Then go to RUN with phy_pause_req = 0.
- RUN:
  - phy_pause_req = 0.
  - tx path is combinational pass-through:
    - phy_tx = s_tx.
    - phy_tx_valid = s_tx_valid && tx_en && tx_cnt < len.
    - s_tx_ready = phy_tx_ready && tx_en && tx_cnt < len.
    - tx_cnt increments on each phy_tx handshake.
  - rx path is pass-through in the same way, gated by rx_en && rx_cnt < len.
    - rx_cnt increments on each phy_rx handshake.
    - An rx word arriving after rx_cnt == len is not accepted (phy_rx_ready = 0).
  - tx_done = !tx_en || tx_cnt == len; rx_done = !rx_en || rx_cnt == len.
  - When tx_done && rx_done: go to DRAIN and set phy_pause_req = 1 on the same edge.
- DRAIN:
  - phy_pause_req = 1; wait for phy_pause_ack = 1.
  - Then go to IDLE and assert done for exactly that one cycle.
  - Ack may take arbitrarily long; no timeout.
- Stream gating:
  - Outside RUN, s_tx_ready = 0, m_rx_valid = 0, phy_tx_valid = 0, phy_rx_ready = 0.
- Counters: LEN_WIDTH bits, with no wrap, because they saturate at len by gating.
- Config outputs change only on the IDLE→APPLY edge, so they are stable whenever phy_pause_ack = 0.
- cmd_valid during busy is ignored (cmd_ready = 0).

Test Plan:
1. Reset, then PHY ack = 1 → cmd_ready = 1, phy_mode_select = 1, phy_pause_req = 1, done = 0.
2. Full-duplex command: len = 3, tx_en = 1, rx_en = 1, data_length = 8, baud = 4, PHY model echoes tx.
   - Send 0xA5, 0x3C, 0xFF → m_rx carries the same three words.
   - phy_pause_req falls 1 cycle after the accept cycle.
   - done pulses once after ack returns; busy = 0 afterwards.
3. tx-only command, len = 2 → exactly 2 s_tx handshakes.
   - A 3rd s_tx_valid is held with s_tx_ready = 0.
   - m_rx_valid is never asserted.
4. rx-only with m_rx_ready held low for 10 cycles mid-transfer → stays in RUN with no words lost; rx_cnt reaches len = 4 → done.
5. cmd_len = 0 → accepted, done on the next cycle, state stays IDLE, phy_pause_req stays 1, config unchanged.
6. rst asserted during RUN after 1 of 4 words → next cycle all outputs at reset values, no done; the next command runs normally.
